row_scan_ctrl: RTL

Sequencer for the pair-row decoder of the crossbar array. It accepts a scan command (single row or full array), drives the decoder's enable and row select, and waits a programmable settle time after each row activation. It then hands each settled row to the column/readout logic through a sample/acknowledge handshake. It sits between the array command interface and the row decoder, and is the only block permitted to drive decoder enable and row select.

---
 rtl/row_scan_if.sv | 30 +++
 rtl/row_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/row_scan_if.sv
// Bundle between the array command port, the pair-row decoder and the readout handshake.
// The master drives commands and sample_ack; the slave (row_scan_ctrl) owns the decoder lines.
interface row_scan_if #(
  parameter int PAIR_ROW_NO = 64,
  parameter int AW          = $clog2(PAIR_ROW_NO)
);
  logic                   start;
  logic                   mode;
  logic [AW-1:0]          row_addr;
  logic [PAIR_ROW_NO-1:0] row_mask;
  logic                   abort;
  logic                   sample_ack;
  logic                   busy;
  logic                   dec_en;
  logic [AW-1:0]          dec_row_sel;
  logic                   sample;
  logic [AW-1:0]          sample_row;
  logic                   done;
  logic                   aborted;

  modport master (
    output start, mode, row_addr, row_mask, abort, sample_ack,
    input  busy, dec_en, dec_row_sel, sample, sample_row, done, aborted
  );

  modport slave (
    input  start, mode, row_addr, row_mask, abort, sample_ack,
    output busy, dec_en, dec_row_sel, sample, sample_row, done, aborted
  );
endinterface

// File: rtl/row_scan_ctrl.sv
// Pair-row scan sequencer: break-before-make row activation, settle wait, sample/ack hand-off.
// Define ROW_SCAN_MASK_EN to honour row_mask during full scans; otherwise the mask port is ignored.
module row_scan_ctrl #(
  parameter int PAIR_ROW_NO = 64,
  parameter int SETTLE_CYC  = 4
) (
  input logic       clk,
  input logic       rst_n,
  row_scan_if.slave bus
);
  localparam int AW = $clog2(PAIR_ROW_NO);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [AW-1:0] LAST_ROW    = AW'(PAIR_ROW_NO - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    SETUP,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] row_reg, row_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic          mode_reg, mode_next;

  logic          busy_reg, busy_next;
  logic          dec_en_reg, dec_en_next;
  logic [AW-1:0] sel_reg, sel_next;
  logic          sample_reg, sample_next;
  logic [AW-1:0] sample_row_reg, sample_row_next;
  logic          done_reg, done_next;
  logic          aborted_reg, aborted_next;

  logic          row_last;
  logic          row_masked;

  assign row_last = (row_reg == LAST_ROW);

`ifdef ROW_SCAN_MASK_EN
  logic [PAIR_ROW_NO-1:0] mask_reg, mask_next;

  // Single-row commands target an explicit address, so the mask only applies to full scans.
  assign row_masked = mode_reg & mask_reg[row_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end
`else
  logic unused_mask;

  assign unused_mask = ^bus.row_mask;
  assign row_masked  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      settle_reg     <= '0;
      mode_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      dec_en_reg     <= 1'b0;
      sel_reg        <= '0;
      sample_reg     <= 1'b0;
      sample_row_reg <= '0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      settle_reg     <= settle_next;
      mode_reg       <= mode_next;
      busy_reg       <= busy_next;
      dec_en_reg     <= dec_en_next;
      sel_reg        <= sel_next;
      sample_reg     <= sample_next;
      sample_row_reg <= sample_row_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    settle_next  = settle_reg;
    mode_next    = mode_reg;
    aborted_next = 1'b0;
`ifdef ROW_SCAN_MASK_EN
    mask_next    = mask_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          mode_next  = bus.mode;
          row_next   = bus.mode ? '0 : bus.row_addr;
`ifdef ROW_SCAN_MASK_EN
          mask_next  = bus.row_mask;
`endif
          state_next = SEEK;
        end
      end

      SEEK: begin
        if (bus.abort) begin
          state_next   = DONE;
          aborted_next = 1'b1;
        end else if (row_masked) begin
          if (row_last) begin
            state_next = DONE;
          end else begin
            row_next = row_reg + AW'(1);
          end
        end else begin
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (bus.abort) begin
          state_next   = DONE;
          aborted_next = 1'b1;
        end else begin
          settle_next = SETTLE_LOAD;
          state_next  = SETTLE;
        end
      end

      SETTLE: begin
        if (bus.abort) begin
          state_next   = DONE;
          aborted_next = 1'b1;
        end else if (settle_reg == SW'(1)) begin
          settle_next = '0;
          state_next  = SAMPLE;
        end else begin
          settle_next = settle_reg - SW'(1);
        end
      end

      SAMPLE: begin
        // Abort wins over a coincident acknowledge.
        if (bus.abort) begin
          state_next   = DONE;
          aborted_next = 1'b1;
        end else if (bus.sample_ack) begin
          if (!mode_reg || row_last) begin
            state_next = DONE;
          end else begin
            row_next   = row_reg + AW'(1);
            state_next = SEEK;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they are registered yet cycle-aligned.
    busy_next       = (state_next != IDLE);
    dec_en_next     = (state_next == SETUP) || (state_next == SETTLE) || (state_next == SAMPLE);
    sel_next        = row_next;
    sample_next     = (state_next == SAMPLE);
    sample_row_next = row_next;
    done_next       = (state_next == DONE);
  end

  assign bus.busy        = busy_reg;
  assign bus.dec_en      = dec_en_reg;
  assign bus.dec_row_sel = sel_reg;
  assign bus.sample      = sample_reg;
  assign bus.sample_row  = sample_row_reg;
  assign bus.done        = done_reg;
  assign bus.aborted     = aborted_reg;
endmodule
